dec_stage: RTL and testbench

//  Registered RV32I/RV32E decode stage with valid/ready handshake on both sides and a 1-entry skid buffer.

---
 rtl/dec_pkg.sv | 74 +++++++
 rtl/dec_core.sv | 175 +++++++++++++++++
 rtl/dec_stage.sv | 125 ++++++++++++
 tb/tb_dec_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared decode definitions: opcode/funct3 constants, instruction classes and
// the decoded bundle carried from dec_core through the dec_stage registers.
package dec_pkg;

  localparam int XLEN_MAX    = 32;
  localparam int REG_IDX_MAX = 5;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_JALR = 3'b000;

  localparam logic [6:0] FUNCT7_BASE = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  localparam logic [11:0] SYS_IMM_ECALL  = 12'h000;
  localparam logic [11:0] SYS_IMM_EBREAK = 12'h001;

  typedef enum logic [3:0] {
    INVALID = 4'd0,
    IMM,
    REG,
    LUI,
    AUIPC,
    JAL,
    JALR,
    BRANCH,
    STORE,
    LOAD,
    EBREAK,
    ECALL,
    FENCE
  } inst_type_e;

  typedef struct packed {
    logic [XLEN_MAX-1:0]    pc;
    logic [REG_IDX_MAX-1:0] rd;
    logic [REG_IDX_MAX-1:0] rs1;
    logic [REG_IDX_MAX-1:0] rs2;
    logic [XLEN_MAX-1:0]    imm;
    logic [3:0]             alu_op;
    inst_type_e             inst_type;
    logic [1:0]             mem_size;
    logic                   mem_sign;
    logic [3:0]             wbmask;
    logic                   illegal;
  } dec_bundle_t;

  function automatic logic [3:0] store_mask(input logic [1:0] size);
    case (size)
      2'd0:    store_mask = 4'b0001;
      2'd1:    store_mask = 4'b0011;
      default: store_mask = 4'b1111;
    endcase
  endfunction

  // RV32E narrows the register file; indices past it make the encoding illegal.
  function automatic logic reg_ok(input logic [REG_IDX_MAX-1:0] idx, input int width);
    reg_ok = (width >= REG_IDX_MAX) || ((idx >> width) == '0);
  endfunction

endpackage

// File: rtl/dec_core.sv
// Purely combinational RV32I/RV32E instruction decoder: raw instruction word
// in, decoded bundle out (pc left zero, filled in by the stage).
module dec_core
  import dec_pkg::*;
#(
  parameter int REG_IDX_W = 5
) (
  input  logic [31:0] inst,
  output dec_bundle_t bundle
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  inst_type_e  itype;
  logic        fmt_ok;
  logic        use_rd;
  logic        use_rs1;
  logic        use_rs2;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic [1:0]  mem_size;
  logic        mem_sign;
  logic [3:0]  wbmask;
  logic        legal;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];
  assign rd     = inst[11:7];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];

  assign imm_i = {{21{inst[31]}}, inst[30:20]};
  assign imm_s = {{21{inst[31]}}, inst[30:25], inst[11:7]};
  assign imm_b = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    itype    = INVALID;
    fmt_ok   = 1'b0;
    use_rd   = 1'b0;
    use_rs1  = 1'b0;
    use_rs2  = 1'b0;
    imm      = '0;
    alu_op   = '0;
    mem_size = '0;
    mem_sign = 1'b0;
    wbmask   = '0;
    case (opcode)
      OPCODE_OP_IMM: begin
        itype   = IMM;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm     = imm_i;
        alu_op  = {(funct3 == FUNCT3_SR) & inst[30], funct3};
        if (funct3 == FUNCT3_SLL)
          fmt_ok = (funct7 == FUNCT7_BASE);
        else if (funct3 == FUNCT3_SR)
          fmt_ok = (funct7 == FUNCT7_BASE) || (funct7 == FUNCT7_ALT);
        else
          fmt_ok = 1'b1;
      end
      OPCODE_OP: begin
        itype   = REG;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        alu_op  = {inst[30], funct3};
        fmt_ok  = (funct7 == FUNCT7_BASE) ||
                  ((funct7 == FUNCT7_ALT) && ((funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SR)));
      end
      OPCODE_LUI: begin
        itype  = LUI;
        use_rd = 1'b1;
        imm    = imm_u;
        fmt_ok = 1'b1;
      end
      OPCODE_AUIPC: begin
        itype  = AUIPC;
        use_rd = 1'b1;
        imm    = imm_u;
        fmt_ok = 1'b1;
      end
      OPCODE_JAL: begin
        itype  = JAL;
        use_rd = 1'b1;
        imm    = imm_j;
        fmt_ok = 1'b1;
      end
      OPCODE_JALR: begin
        itype   = JALR;
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm     = imm_i;
        fmt_ok  = (funct3 == FUNCT3_JALR);
      end
      OPCODE_BRANCH: begin
        itype   = BRANCH;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm     = imm_b;
        alu_op  = {1'b0, funct3};
        fmt_ok  = (funct3 != 3'd2) && (funct3 != 3'd3);
      end
      OPCODE_STORE: begin
        itype    = STORE;
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
        imm      = imm_s;
        mem_size = funct3[1:0];
        wbmask   = store_mask(funct3[1:0]);
        fmt_ok   = (funct3 < 3'd3);
      end
      OPCODE_LOAD: begin
        itype    = LOAD;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        imm      = imm_i;
        mem_size = funct3[1:0];
        mem_sign = !funct3[2];
        fmt_ok   = !(funct3 inside {3'd3, 3'd6, 3'd7});
      end
      OPCODE_MISC_MEM: begin
        itype  = FENCE;
        fmt_ok = 1'b1;
      end
      OPCODE_SYSTEM: begin
        if (inst[31:20] == SYS_IMM_ECALL) begin
          itype  = ECALL;
          fmt_ok = 1'b1;
        end else if (inst[31:20] == SYS_IMM_EBREAK) begin
          itype  = EBREAK;
          fmt_ok = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign legal = fmt_ok && (inst[1:0] == 2'b11) &&
                 (!use_rd  || reg_ok(rd,  REG_IDX_W)) &&
                 (!use_rs1 || reg_ok(rs1, REG_IDX_W)) &&
                 (!use_rs2 || reg_ok(rs2, REG_IDX_W));

  // Illegal bundles carry no payload so execute never sees stale fields.
  always_comb begin
    bundle = '0;
    if (legal) begin
      bundle.rd        = use_rd  ? rd  : '0;
      bundle.rs1       = use_rs1 ? rs1 : '0;
      bundle.rs2       = use_rs2 ? rs2 : '0;
      bundle.imm       = imm;
      bundle.alu_op    = alu_op;
      bundle.inst_type = itype;
      bundle.mem_size  = mem_size;
      bundle.mem_sign  = mem_sign;
      bundle.wbmask    = wbmask;
    end else begin
      bundle.inst_type = INVALID;
      bundle.illegal   = 1'b1;
    end
  end

endmodule

// File: rtl/dec_stage.sv
// Registered decode stage: valid/ready on both sides, 1-entry skid, flush and a
// saturating illegal counter. DEC_STAGE_PERF_EN adds a stall-cycle counter port.
module dec_stage
  import dec_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5,
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_inst,
  input  logic [XLEN-1:0]      in_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      out_pc,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [REG_IDX_W-1:0] out_rs1,
  output logic [REG_IDX_W-1:0] out_rs2,
  output logic [XLEN-1:0]      out_imm,
  output logic [3:0]           out_alu_op,
  output logic [3:0]           out_inst_type,
  output logic [1:0]           out_mem_size,
  output logic                 out_mem_sign,
  output logic [3:0]           out_wbmask,
  output logic                 out_illegal,
  output logic [ILL_CNT_W-1:0] ill_count
`ifdef DEC_STAGE_PERF_EN
  ,
  output logic [31:0]          perf_stall_cnt
`endif
);

  dec_bundle_t          core_b;
  dec_bundle_t          dec_b;
  dec_bundle_t          out_q;
  dec_bundle_t          skid_q;
  logic                 out_valid_q;
  logic                 skid_valid_q;
  logic [ILL_CNT_W-1:0] ill_cnt_q;
  logic                 in_fire;
  logic                 out_fire;
  logic                 load_out;

  dec_core #(
    .REG_IDX_W(REG_IDX_W)
  ) u_core (
    .inst  (in_inst),
    .bundle(core_b)
  );

  always_comb begin
    dec_b    = core_b;
    dec_b.pc = in_pc;
  end

  assign in_ready = !skid_valid_q;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;
  assign load_out = !out_valid_q || out_ready;

  // Skid has priority into the output register to preserve order.
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_q        <= '0;
      skid_q       <= '0;
    end else if (flush) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
    end else if (load_out) begin
      if (skid_valid_q) begin
        out_q        <= skid_q;
        out_valid_q  <= 1'b1;
        skid_valid_q <= in_fire;
        if (in_fire) skid_q <= dec_b;
      end else begin
        out_valid_q <= in_fire;
        if (in_fire) out_q <= dec_b;
      end
    end else if (in_fire) begin
      skid_q       <= dec_b;
      skid_valid_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset)
      ill_cnt_q <= '0;
    else if (out_fire && out_q.illegal && !(&ill_cnt_q))
      ill_cnt_q <= ill_cnt_q + 1'b1;
  end

`ifdef DEC_STAGE_PERF_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clock) begin
    if (reset)
      stall_cnt_q <= '0;
    else if (out_valid_q && !out_ready)
      stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

  assign out_valid     = out_valid_q;
  assign out_pc        = out_q.pc;
  assign out_rd        = out_q.rd[REG_IDX_W-1:0];
  assign out_rs1       = out_q.rs1[REG_IDX_W-1:0];
  assign out_rs2       = out_q.rs2[REG_IDX_W-1:0];
  assign out_imm       = out_q.imm;
  assign out_alu_op    = out_q.alu_op;
  assign out_inst_type = out_q.inst_type;
  assign out_mem_size  = out_q.mem_size;
  assign out_mem_sign  = out_q.mem_sign;
  assign out_wbmask    = out_q.wbmask;
  assign out_illegal   = out_q.illegal;
  assign ill_count     = ill_cnt_q;

endmodule

// File: tb/tb_dec_stage.sv
// Scoreboard bench for dec_stage: an RV32I and an RV32E instance share one
// stimulus stream; expected bundles are queued per instance and checked on output.
module tb_dec_stage;
  import dec_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic [3:0]  itype;
    logic [1:0]  mem_size;
    logic        mem_sign;
    logic [3:0]  wbmask;
    logic        illegal;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready, out_valid, out_mem_sign, out_illegal;
  logic [31:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [3:0]  out_alu_op, out_inst_type, out_wbmask;
  logic [1:0]  out_mem_size;
  logic [7:0]  ill_count;

  logic        in_ready_e, out_valid_e, out_mem_sign_e, out_illegal_e;
  logic [31:0] out_pc_e, out_imm_e;
  logic [3:0]  out_rd_e, out_rs1_e, out_rs2_e;
  logic [3:0]  out_alu_op_e, out_inst_type_e, out_wbmask_e;
  logic [1:0]  out_mem_size_e;
  logic [7:0]  ill_count_e;
`ifdef DEC_STAGE_PERF_EN
  logic [31:0] perf_m, perf_e;
`endif

  always #5 clock = ~clock;

  dec_stage dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_inst_type(out_inst_type), .out_mem_size(out_mem_size),
    .out_mem_sign(out_mem_sign), .out_wbmask(out_wbmask), .out_illegal(out_illegal),
    .ill_count(ill_count)
`ifdef DEC_STAGE_PERF_EN
    , .perf_stall_cnt(perf_m)
`endif
  );

  dec_stage #(.REG_IDX_W(4)) dut_e (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_e), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid_e), .out_ready(out_ready), .out_pc(out_pc_e),
    .out_rd(out_rd_e), .out_rs1(out_rs1_e), .out_rs2(out_rs2_e), .out_imm(out_imm_e),
    .out_alu_op(out_alu_op_e), .out_inst_type(out_inst_type_e), .out_mem_size(out_mem_size_e),
    .out_mem_sign(out_mem_sign_e), .out_wbmask(out_wbmask_e), .out_illegal(out_illegal_e),
    .ill_count(ill_count_e)
`ifdef DEC_STAGE_PERF_EN
    , .perf_stall_cnt(perf_e)
`endif
  );

  exp_t act_m, act_e;
  assign act_m = {out_pc, out_rd, out_rs1, out_rs2, out_imm, out_alu_op, out_inst_type,
                  out_mem_size, out_mem_sign, out_wbmask, out_illegal};
  assign act_e = {out_pc_e, 1'b0, out_rd_e, 1'b0, out_rs1_e, 1'b0, out_rs2_e, out_imm_e,
                  out_alu_op_e, out_inst_type_e, out_mem_size_e, out_mem_sign_e,
                  out_wbmask_e, out_illegal_e};

  exp_t        q_m[$];
  exp_t        q_e[$];
  exp_t        pop_m, pop_e;
  int          tests = 0;
  int          fails = 0;
  int          ill_m = 0;
  int          ill_e = 0;
  logic [31:0] pc_cnt;
  logic        stall_prev = 1'b0;
  logic [67:0] held;
  logic [7:0]  ill_saved;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input inst_type_e t, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [3:0] alu, input logic [1:0] sz, input logic sg,
                              input logic [3:0] msk);
    exp_t e;
    e.pc = '0; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.alu_op = alu;
    e.itype = t; e.mem_size = sz; e.mem_sign = sg; e.wbmask = msk;
    e.illegal = (t == INVALID);
    return e;
  endfunction

  function automatic exp_t ill();
    return mk(INVALID, 5'd0, 5'd0, 5'd0, 32'h0, 4'h0, 2'd0, 1'b0, 4'h0);
  endfunction

  // Monitor: pop one expectation per accepted bundle, independent of the stimulus.
  always @(negedge clock) begin
    if (!reset) begin
      if (out_valid && out_ready) begin
        if (q_m.size() == 0) begin
          tests++; fails++;
          $display("FAIL main_unexpected pc=%0h required=no_bundle", out_pc);
        end else begin
          pop_m = q_m.pop_front();
          check("main_bundle", 128'(act_m), 128'(pop_m));
          check("main_ill_count", 128'(ill_count), 128'(ill_m));
          check("ready_match", 128'(in_ready_e), 128'(in_ready));
          if (pop_m.illegal && ill_m < 255) ill_m++;
        end
      end
      if (out_valid_e && out_ready) begin
        if (q_e.size() == 0) begin
          tests++; fails++;
          $display("FAIL e_unexpected pc=%0h required=no_bundle", out_pc_e);
        end else begin
          pop_e = q_e.pop_front();
          check("e_bundle", 128'(act_e), 128'(pop_e));
          check("e_ill_count", 128'(ill_count_e), 128'(ill_e));
          if (pop_e.illegal && ill_e < 255) ill_e++;
        end
      end
      if (stall_prev && out_valid)
        check("stall_hold", 128'({out_pc, out_imm, out_inst_type}), 128'(held));
      stall_prev = out_valid && !out_ready;
      held       = {out_pc, out_imm, out_inst_type};
    end
  end

  task automatic send(input logic [31:0] inst, input exp_t em, input bit e_ill);
    exp_t ee;
    int   guard;
    guard = 0;
    em.pc = pc_cnt;
    ee    = e_ill ? ill() : em;
    ee.pc = pc_cnt;
    in_valid = 1'b1;
    in_inst  = inst;
    in_pc    = pc_cnt;
    while (!in_ready && guard < 200) begin
      @(posedge clock); #1;
      guard++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL send_timeout pc=%0h in_ready=%0b required=1", pc_cnt, in_ready);
      in_valid = 1'b0;
    end else begin
      q_m.push_back(em);
      q_e.push_back(ee);
      @(posedge clock); #1;
      in_valid = 1'b0;
    end
    pc_cnt = pc_cnt + 32'd4;
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((q_m.size() != 0 || q_e.size() != 0) && g < 100) begin
      @(posedge clock); #1;
      g++;
    end
    if (q_m.size() != 0 || q_e.size() != 0) begin
      tests++; fails++;
      $display("FAIL drain_timeout left=%0d required=0", q_m.size() + q_e.size());
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0;
    out_ready = 1'b1; pc_cnt = 32'h1000;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_ill_count", 128'(ill_count), 128'(0));
    check("rst_out_pc", 128'(out_pc), 128'(0));
    check("rst_out_imm", 128'(out_imm), 128'(0));

    send(32'hFFF10093, mk(IMM,    5'd1,  5'd2, 5'd0, 32'hFFFFFFFF, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h405251B3, mk(REG,    5'd3,  5'd4, 5'd5, 32'h0,        4'hD, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h805201B3, ill(), 1'b1);
    send(32'h405201B3, mk(REG,    5'd3,  5'd4, 5'd5, 32'h0,        4'h8, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'hFE000EE3, mk(BRANCH, 5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h001000EF, mk(JAL,    5'd1,  5'd0, 5'd0, 32'h00000800, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h00832283, mk(LOAD,   5'd5,  5'd6, 5'd0, 32'h8,        4'h0, 2'd2, 1'b1, 4'h0), 1'b0);
    send(32'hFFF0C383, mk(LOAD,   5'd7,  5'd1, 5'd0, 32'hFFFFFFFF, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h00219323, mk(STORE,  5'd0,  5'd3, 5'd2, 32'h6,        4'h0, 2'd1, 1'b0, 4'h3), 1'b0);
    send(32'hFE42AC23, mk(STORE,  5'd0,  5'd5, 5'd4, 32'hFFFFFFF8, 4'h0, 2'd2, 1'b0, 4'hF), 1'b0);
    send(32'h12345537, mk(LUI,    5'd10, 5'd0, 5'd0, 32'h12345000, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'hFFFFF597, mk(AUIPC,  5'd11, 5'd0, 5'd0, 32'hFFFFF000, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h004100E7, mk(JALR,   5'd1,  5'd2, 5'd0, 32'h4,        4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h40335293, mk(IMM,    5'd5,  5'd6, 5'd0, 32'h403,      4'hD, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h40109093, ill(), 1'b1);
    send(32'h00000073, mk(ECALL,  5'd0,  5'd0, 5'd0, 32'h0,        4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h00100073, mk(EBREAK, 5'd0,  5'd0, 5'd0, 32'h0,        4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h0FF0000F, mk(FENCE,  5'd0,  5'd0, 5'd0, 32'h0,        4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'hFE002EE3, ill(), 1'b1);
    send(32'h0000007F, ill(), 1'b1);
    send(32'h00003083, ill(), 1'b1);
    send(32'h00000833, mk(REG,    5'd16, 5'd0, 5'd0, 32'h0,        4'h0, 2'd0, 1'b0, 4'h0), 1'b1);
    drain();

    // Backpressure: first bundle holds the output, second lands in the skid.
    out_ready = 1'b0;
    send(32'hFFF10093, mk(IMM, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    send(32'h12345537, mk(LUI, 5'd10, 5'd0, 5'd0, 32'h12345000, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    check("skid_full_in_ready", 128'(in_ready), 128'(0));
    check("skid_full_in_ready_e", 128'(in_ready_e), 128'(0));
    check("stall_out_valid", 128'(out_valid), 128'(1));
    repeat (3) @(posedge clock);
    #1;
    out_ready = 1'b1;
    drain();

    // Flush with output and skid occupied; the held illegal must not be counted.
    out_ready = 1'b0;
    send(32'h00000000, ill(), 1'b1);
    send(32'h004100E7, mk(JALR, 5'd1, 5'd2, 5'd0, 32'h4, 4'h0, 2'd0, 1'b0, 4'h0), 1'b0);
    check("flush_pre_in_ready", 128'(in_ready), 128'(0));
    ill_saved = ill_count;
    flush    = 1'b1;
    in_valid = 1'b1;
    in_inst  = 32'hFFF10093;
    @(posedge clock); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    q_m.delete();
    q_e.delete();
    check("flush_out_valid", 128'(out_valid), 128'(0));
    check("flush_in_ready", 128'(in_ready), 128'(1));
    check("flush_out_valid_e", 128'(out_valid_e), 128'(0));
    check("flush_ill_count", 128'(ill_count), 128'(ill_saved));
    out_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("flush_stays_empty", 128'(out_valid), 128'(0));
    send(32'h00832283, mk(LOAD, 5'd5, 5'd6, 5'd0, 32'h8, 4'h0, 2'd2, 1'b1, 4'h0), 1'b0);
    drain();

    for (int i = 0; i < 300; i++) send(32'h00000000, ill(), 1'b1);
    drain();
    check("ill_saturated", 128'(ill_count), 128'(255));
    check("ill_saturated_e", 128'(ill_count_e), 128'(255));
    check("ill_model_final", 128'(ill_count), 128'(ill_m));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
